// File: rtl/ifft_butterfly_dif.sv
// Radix-2 decimation-in-frequency (Gentleman-Sande) butterfly, inverse-FFT path.
//   out0 = (x + y) * 2^-SCALE
//   out1 = ((x - y) * conj(W)) * 2^-SCALE
// Three register stages with valid/ready on both sides. A stage advances when
// its downstream slot is empty or draining, so bubbles collapse and a full pipe
// sustains one result per clock. Results are rounded half-up and clamped to
// the DW-bit signed range; nothing ever wraps.
// Build option: define BUTTERFLY_SAT_FLAG_EN to add the ovf_sticky output,
// a flag that latches once any clamped result has been handed downstream.
module ifft_butterfly_dif #(
  parameter int DW    = 16,
  parameter int SCALE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] xr,
  input  logic signed [DW-1:0] xi,
  input  logic signed [DW-1:0] yr,
  input  logic signed [DW-1:0] yi,
  input  logic signed [DW-1:0] wr,
  input  logic signed [DW-1:0] wi,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out0_r,
  output logic signed [DW-1:0] out0_i,
  output logic signed [DW-1:0] out1_r,
  output logic signed [DW-1:0] out1_i
`ifdef BUTTERFLY_SAT_FLAG_EN
  ,
  output logic                 ovf_sticky
`endif
);

  localparam int STAGES = 3;
  localparam int SW     = DW + 1;      // sum / difference width, never overflows
  localparam int PW     = 2*DW + 1;    // partial product width
  localparam int RW     = 2*DW + 3;    // stage-3 working width: exact t plus rounding headroom
  localparam int SH0    = SCALE;
  localparam int SH1    = DW - 1 + SCALE;

  // Half-LSB rounding constants; (1<<0)>>1 collapses to 0, so SCALE=0 leaves s untouched
  localparam logic [RW-1:0]        ONE  = {{(RW-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0]        RND0 = (ONE << SH0) >> 1;
  localparam logic [RW-1:0]        RND1 = (ONE << SH1) >> 1;
  localparam logic signed [RW-1:0] SMAX = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [RW-1:0] SMIN = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef struct packed {
    logic [SW-1:0] sr, si, dr, di;
    logic [DW-1:0] wr, wi;
  } s1_t;

  typedef struct packed {
    logic [PW-1:0] prr, pii, pir, pri;
    logic [SW-1:0] sr, si;
  } s2_t;

  typedef struct packed {
    logic [DW-1:0] o0r, o0i, o1r, o1i;
  } rsp_t;

  function automatic logic signed [RW-1:0] sx_s(input logic [SW-1:0] v);
    return {{(RW-SW){v[SW-1]}}, v};
  endfunction

  function automatic logic signed [RW-1:0] sx_p(input logic [PW-1:0] v);
    return {{(RW-PW){v[PW-1]}}, v};
  endfunction

  function automatic logic [DW-1:0] sat(input logic signed [RW-1:0] v);
    if (v > SMAX)      return SMAX[DW-1:0];
    else if (v < SMIN) return SMIN[DW-1:0];
    else               return v[DW-1:0];
  endfunction

  // ---------------------------------------------------------------- handshake
  logic [STAGES:1] vld_pipe;
  logic            adv1, adv2, adv3;

  assign adv3      = !vld_pipe[3] || out_ready;
  assign adv2      = !vld_pipe[2] || adv3;
  assign adv1      = !vld_pipe[1] || adv2;
  assign in_ready  = adv1;
  assign out_valid = vld_pipe[STAGES];

  // Valid shift register: each slot reloads only when it may hand its content on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      if (adv1) vld_pipe[1] <= in_valid;
      if (adv2) vld_pipe[2] <= vld_pipe[1];
      if (adv3) vld_pipe[3] <= vld_pipe[2];
    end
  end

  // ---------------------------------------------------------------- stage 1
  s1_t s1_d, s1_q;

  // Sum and difference at DW+1 bits; twiddle rides along with its operands
  always_comb begin
    s1_d.sr = {xr[DW-1], xr} + {yr[DW-1], yr};
    s1_d.si = {xi[DW-1], xi} + {yi[DW-1], yi};
    s1_d.dr = {xr[DW-1], xr} - {yr[DW-1], yr};
    s1_d.di = {xi[DW-1], xi} - {yi[DW-1], yi};
    s1_d.wr = wr;
    s1_d.wi = wi;
  end

  // Stage-1 register, loaded on an input transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                s1_q <= '0;
    else if (adv1 && in_valid) s1_q <= s1_d;
  end

  // ---------------------------------------------------------------- stage 2
  s2_t                  s2_d, s2_q;
  logic signed [PW-1:0] dr_e, di_e, wr_e, wi_e;

  // Four real products of d * conj(W); operands widened so the product is exact
  always_comb begin
    dr_e     = {{(PW-SW){s1_q.dr[SW-1]}}, s1_q.dr};
    di_e     = {{(PW-SW){s1_q.di[SW-1]}}, s1_q.di};
    wr_e     = {{(PW-DW){s1_q.wr[DW-1]}}, s1_q.wr};
    wi_e     = {{(PW-DW){s1_q.wi[DW-1]}}, s1_q.wi};
    s2_d.prr = dr_e * wr_e;
    s2_d.pii = di_e * wi_e;
    s2_d.pir = di_e * wr_e;
    s2_d.pri = dr_e * wi_e;
    s2_d.sr  = s1_q.sr;
    s2_d.si  = s1_q.si;
  end

  // Stage-2 register; the sum path is only delayed here to stay aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   s2_q <= '0;
    else if (adv2 && vld_pipe[1]) s2_q <= s2_d;
  end

  // ---------------------------------------------------------------- stage 3
  rsp_t                 r_d, r_q;
  logic signed [RW-1:0] v0r, v0i, v1r, v1i;

  // conj(W): tr = dr*wr + di*wi, ti = di*wr - dr*wi; round half-up, scale, clamp
  always_comb begin
    v0r     = $signed(sx_s(s2_q.sr) + RND0) >>> SH0;
    v0i     = $signed(sx_s(s2_q.si) + RND0) >>> SH0;
    v1r     = $signed(sx_p(s2_q.prr) + sx_p(s2_q.pii) + RND1) >>> SH1;
    v1i     = $signed(sx_p(s2_q.pir) - sx_p(s2_q.pri) + RND1) >>> SH1;
    r_d.o0r = sat(v0r);
    r_d.o0i = sat(v0i);
    r_d.o1r = sat(v1r);
    r_d.o1i = sat(v1i);
  end

  // Output register; held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_q <= '0;
    else if (adv3 && vld_pipe[2]) r_q <= r_d;
  end

  assign out0_r = r_q.o0r;
  assign out0_i = r_q.o0i;
  assign out1_r = r_q.o1r;
  assign out1_i = r_q.o1i;

`ifdef BUTTERFLY_SAT_FLAG_EN
  function automatic logic clipped(input logic signed [RW-1:0] v);
    return (v > SMAX) || (v < SMIN);
  endfunction

  logic clip_d, clip_q;

  // Any of the four stage-3 results hit a rail
  always_comb clip_d = clipped(v0r) || clipped(v0i) || clipped(v1r) || clipped(v1i);

  // Clamp marker travels with the result it belongs to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   clip_q <= 1'b0;
    else if (adv3 && vld_pipe[2]) clip_q <= clip_d;
  end

  // Latch once a clamped result is actually taken downstream; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               ovf_sticky <= 1'b0;
    else if (out_valid && out_ready && clip_q) ovf_sticky <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ifft_butterfly_dif.sv
// Directed bench for ifft_butterfly_dif. Two instances share stimulus and
// handshake: dut_a with SCALE=1, dut_b with SCALE=0. Expected values are
// hand-computed constants or simple closed forms of the vector index.
module tb_ifft_butterfly_dif;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 in_valid, out_ready;
  logic signed [DW-1:0] xr, xi, yr, yi, wr, wi;
  logic                 in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic signed [DW-1:0] a0r, a0i, a1r, a1i, b0r, b0i, b1r, b1i;
`ifdef BUTTERFLY_SAT_FLAG_EN
  logic                 ovf_a, ovf_b;
`endif

  ifft_butterfly_dif #(.DW(DW), .SCALE(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .xr(xr), .xi(xi), .yr(yr), .yi(yi), .wr(wr), .wi(wi),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out0_r(a0r), .out0_i(a0i), .out1_r(a1r), .out1_i(a1i)
`ifdef BUTTERFLY_SAT_FLAG_EN
    , .ovf_sticky(ovf_a)
`endif
  );

  ifft_butterfly_dif #(.DW(DW), .SCALE(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .xr(xr), .xi(xi), .yr(yr), .yi(yi), .wr(wr), .wi(wi),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out0_r(b0r), .out0_i(b0i), .out1_r(b1r), .out1_i(b1i)
`ifdef BUTTERFLY_SAT_FLAG_EN
    , .ovf_sticky(ovf_b)
`endif
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drv(input int a, input int b, input int c, input int d, input int e, input int f);
    xr = DW'(a); xi = DW'(b); yr = DW'(c); yi = DW'(d); wr = DW'(e); wi = DW'(f);
  endtask

  // One vector into an empty pipe; lat counts cycles from offer to out_valid
  task automatic run1(input int a, input int b, input int c, input int d, input int e, input int f,
                      input bit sel_b, output int lat);
    drv(a, b, c, d, e, f);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!(sel_b ? out_valid_b : out_valid_a) && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, acc, got, sent, stray;
    bit take;

    in_valid = 1'b0; out_ready = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", out_valid_a, 0);
    chk("rst_o0r", a0r, 0);
    chk("rst_o1i", a1i, 0);
`ifdef BUTTERFLY_SAT_FLAG_EN
    chk("rst_ovf", ovf_b, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy", in_ready_a, 1);

    // basic SCALE=1 butterfly
    run1(1000, 0, 200, 0, 32767, 0, 1'b0, lat);
    chk("t1_lat", lat, 3);
    chk("t1_o0r", a0r, 600);
    chk("t1_o0i", a0i, 0);
    chk("t1_o1r", a1r, 400);
    chk("t1_o1i", a1i, 0);
    @(posedge clk); #1;
    chk("t1_pulse", out_valid_a, 0);

    // SCALE=0, W = -j: conjugation turns it into +j
    run1(150, 0, 50, 0, 0, -32768, 1'b1, lat);
    chk("t2_lat", lat, 3);
    chk("t2_o0r", b0r, 200);
    chk("t2_o0i", b0i, 0);
    chk("t2_o1r", b1r, 0);
    chk("t2_o1i", b1i, 100);
    @(posedge clk); #1;

    // saturation of the sum and of the W=-1, d=-1.0 product
    run1(32767, 0, 32767, 0, 32767, 0, 1'b1, lat);
    chk("t3_o0r_sat", b0r, 32767);
    chk("t3_o1r", b1r, 0);
    chk("t3_a_o0r", a0r, 32767);
    @(posedge clk); #1;
    run1(-32768, 0, 0, 0, -32768, 0, 1'b1, lat);
    chk("t3_o1r_sat", b1r, 32767);
    chk("t3_o0r_min", b0r, -32768);
    chk("t3_o1i", b1i, 0);
    chk("t3_a_o1r", a1r, 16384);
    chk("t3_a_o0r2", a0r, -16384);
    @(posedge clk); #1;
`ifdef BUTTERFLY_SAT_FLAG_EN
    chk("t3_ovf_b", ovf_b, 1);
    chk("t3_ovf_a", ovf_a, 0);
`endif

    // backpressure: 4 offers against a stalled consumer
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      if (acc < 4) begin drv(400*(acc+1), 8, 200, 4, 32767, 0); in_valid = 1'b1; end
      else in_valid = 1'b0;
      take = in_valid && in_ready_a;
      @(posedge clk); #1;
      if (take) acc++;
    end
    chk("t4_acc3", acc, 3);
    chk("t4_rdy_a", in_ready_a, 0);
    chk("t4_rdy_b", in_ready_b, 0);
    chk("t4_vld", out_valid_a, 1);
    chk("t4_o0r", a0r, 300);
    chk("t4_o1r", a1r, 100);
    @(posedge clk); #1;
    chk("t4_hold_vld", out_valid_a, 1);
    chk("t4_hold_o0r", a0r, 300);
    chk("t4_hold_o1r", a1r, 100);
    out_ready = 1'b1;
    #1;
    chk("t4_fullrdy", in_ready_a, 1);
    got = 0;
    for (int c = 0; c < 12; c++) begin
      if (acc < 4) begin drv(400*(acc+1), 8, 200, 4, 32767, 0); in_valid = 1'b1; end
      else in_valid = 1'b0;
      take = in_valid && in_ready_a;
      if (out_valid_a) begin
        chk("t4_d_o0r", a0r, 200*(got+1) + 100);
        chk("t4_d_o1r", a1r, 200*(got+1) - 100);
        chk("t4_d_o0i", a0i, 6);
        chk("t4_d_o1i", a1i, 2);
        got++;
      end
      @(posedge clk); #1;
      if (take) acc++;
    end
    chk("t4_acc4", acc, 4);
    chk("t4_cnt", got, 4);

    // throughput: 16 back-to-back vectors
    got = 0; sent = 0;
    for (int c = 0; c < 24; c++) begin
      if (sent < 16) begin drv(64*sent, 0, 0, sent, 32767, 0); in_valid = 1'b1; end
      else in_valid = 1'b0;
      take = in_valid && in_ready_a;
      if (in_valid) chk("t5_rdy", in_ready_a, 1);
      if (out_valid_a) begin
        chk("t5_cyc", c, got + 3);
        chk("t5_o0r", a0r, 32*got);
        chk("t5_o1r", a1r, 32*got);
        chk("t5_o0i", a0i, (got+1)/2);
        got++;
      end
      @(posedge clk); #1;
      if (take) sent++;
    end
    chk("t5_cnt", got, 16);

    // reset with two items in flight
    drv(5000, 0, 1000, 0, 32767, 0); in_valid = 1'b1;
    @(posedge clk); #1;
    drv(6000, 0, 1000, 0, 32767, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("t6_pre_vld", out_valid_a, 1);
    chk("t6_pre_o0r", a0r, 3000);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_vld", out_valid_a, 0);
    chk("t6_o0r", a0r, 0);
    chk("t6_o1r", a1r, 0);
    chk("t6_b_o0r", b0r, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid_a || out_valid_b) stray++;
    end
    chk("t6_stale", stray, 0);
`ifdef BUTTERFLY_SAT_FLAG_EN
    chk("t6_ovf_clr", ovf_b, 0);
`endif
    run1(300, 0, 100, 0, 32767, 0, 1'b0, lat);
    chk("t6_lat", lat, 3);
    chk("t6_o0r", a0r, 200);
    chk("t6_o1r", a1r, 100);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/ifft_butterfly_dif.md
Name: ifft_butterfly_dif

Overview:
- Radix-2 decimation-in-frequency (Gentleman-Sande) butterfly for the inverse-FFT path.
- Inverse counterpart of the forward DIT butterfly:
  - out0 = (x + y) * 2^-SCALE
  - out1 = ((x − y) * conj(W)) * 2^-SCALE
- 3-stage pipeline with valid/ready handshake on both sides.
- Sits between IFFT stage memories and the address/twiddle sequencer. Operands are Q1.15.

Parameters:
- DW, 16, data and twiddle width (signed Q1.(DW-1)).
- SCALE, 1, 1 = halve both outputs per stage (block-growth control); 0 = no scaling.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block accepts operands this cycle.
- xr, xi  in  DW  operand x (signed).
- yr, yi  in  DW  operand y (signed).
- wr, wi  in  DW  twiddle W (signed); the block conjugates it internally.
- out_valid  out  1  results valid.
- out_ready  in  1  downstream accepts results.
- out0_r, out0_i  out  DW  scaled x + y.
- out1_r, out1_i  out  DW  scaled (x − y)·conj(W).

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid flags and all data registers clear to 0. Therefore out_valid = 0 and all outputs = 0. in_ready is combinational and equals 1 while reset is deasserted and the pipe is empty.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Data and valid outputs are held stable while out_valid && !out_ready.
- Stall logic:
  - Stage k advances when its downstream slot is empty or is advancing.
  - in_ready = !s1_valid || s1_advance.
  - Bubbles collapse; full throughput is 1 result per cycle.
- Latency: 3 cycles from input acceptance to out_valid, with out_ready held high.
- Stage 1:
  - sr = xr + yr, si = xi + yi, dr = xr − yr, di = xi − yi, each DW+1 bits, sign-extended, no overflow.
  - W is registered alongside.
- Stage 2: products, 2·DW+1 bits each: dr·wr, di·wi, di·wr, dr·wi.
- Stage 3:
  - tr = dr·wr + di·wi; ti = di·wr − dr·wi. Exact sum at 2·DW+2 bits.
  - out1 = round(t >>> (DW−1+SCALE)); round half-up (add 2^(DW−2+SCALE) before the shift).
  - out0 = round(s >>> SCALE); with SCALE = 0 this is the identity.
  - sr/si travel through stage 2 in delay registers.
- Saturation: every result is clamped to [−2^(DW−1), 2^(DW−1)−1] before registering. No wrap-around ever.
- Corner case: W = −1 (wr = −32768, wi = 0) with d = −32768 gives +1.0, which saturates to 32767.
- Simultaneous output drain and input acceptance on a full pipe: both occur, and the pipe stays full.
- Reset mid-operation: in-flight data is discarded. No stale out_valid appears after rst_n rises.
- No internal state other than the pipeline registers. The twiddle is sampled with the operands, so there is no separate W load.

Optional Feature:
- Macro: BUTTERFLY_SAT_FLAG_EN.
- Defined:
  - Adds output port ovf_sticky (1 bit).
  - Set to 1 in the cycle after any stage-3 result, for an accepted output, is clamped.
  - Stays set until rst_n is asserted.
  - Reset value 0.
- Undefined: the port and its logic are absent. Saturation behaviour is unchanged.

Test Plan:
1. SCALE=1; x=(1000,0), y=(200,0), W=(32767,0), out_ready=1 -> 3 cycles later out0=(600,0), out1=(400,0), out_valid=1 for one cycle.
2. SCALE=0; x=(150,0), y=(50,0), W=(0,−32768) -> out0=(200,0), out1=(0,100); confirms the twiddle is conjugated.
3. SCALE=0; x=(32767,0), y=(32767,0), W=(32767,0) -> out0=(32767,0) saturated, out1=(0,0); ovf_sticky=1 when the macro is defined. Separately, x=(−32768,0), y=(0,0), W=(−32768,0) -> out1_r=32767.
4. Backpressure: hold out_ready=0 and offer 4 back-to-back inputs -> exactly 3 are accepted, then in_ready=0 and out0/out1 stay stable. Releasing out_ready drains all 4 results in order, with no loss or duplication.
5. Throughput: 16 consecutive inputs with out_ready=1 -> in_ready stays 1 and 16 results arrive on 16 consecutive cycles starting at cycle 3.
6. Reset mid-stream: assert rst_n=0 asynchronously with 2 items in flight -> out_valid and outputs go 0 immediately. After release, none of the flushed items appear, and a new input produces a correct result at latency 3.
